// File: rtl/truth_table_prober.sv
// Drives a 3-input gate through rows 000..111, samples its output per row and
// reassembles the 8-bit truth-table code plus a per-row instability mask.
module truth_table_prober #(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned SAMPLE_CYCLES = 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic       i_abort,
   input  logic       i_dut_out,
   output logic       o_probe_in1,
   output logic       o_probe_in2,
   output logic       o_probe_in3,
   output logic       o_busy,
   output logic       o_done,
   output logic [7:0] o_code,
   output logic [7:0] o_unstable
);

   localparam int unsigned ROW_W    = 3;
   localparam int unsigned SETTLE_W = 8;
   localparam int unsigned SAMPLE_W = 4;
   localparam int unsigned CODE_W   = 8;

   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
   localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(SAMPLE_CYCLES - 1);
   localparam logic [ROW_W-1:0]    ROW_LAST    = '1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t              r_state;
   logic [ROW_W-1:0]    r_row;
   logic [ROW_W-1:0]    r_probe;
   logic [SETTLE_W-1:0] r_settle_cnt;
   logic [SAMPLE_W-1:0] r_sample_cnt;
   logic [CODE_W-1:0]   r_code_sh;
   logic [CODE_W-1:0]   r_unst_sh;
   logic [CODE_W-1:0]   r_code;
   logic [CODE_W-1:0]   r_unstable;
   logic                r_busy;
   logic                r_done;

   logic [ROW_W-1:0]    w_bit_idx;
   logic [ROW_W-1:0]    w_row_next;
   logic                w_first_sample;
   logic                w_last_sample;
   logic                w_abort_hit;

   // Row r lands in code bit 7-r, which for a 3-bit row is simply ~r.
   assign w_bit_idx      = ~r_row;
   assign w_row_next     = r_row + ROW_W'(1);
   assign w_first_sample = (r_sample_cnt == '0);
   assign w_last_sample  = (r_sample_cnt == SAMPLE_LAST);
   assign w_abort_hit    = i_abort && (r_state != ST_IDLE);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_row        <= '0;
         r_probe      <= '0;
         r_settle_cnt <= '0;
         r_sample_cnt <= '0;
         r_code_sh    <= '0;
         r_unst_sh    <= '0;
         r_code       <= '0;
         r_unstable   <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_abort_hit) begin
            // Cancel wins over every other transition; published results stay.
            r_state      <= ST_IDLE;
            r_row        <= '0;
            r_probe      <= '0;
            r_settle_cnt <= '0;
            r_sample_cnt <= '0;
            r_busy       <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_probe <= '0;
                  if (i_start) begin
                     r_state      <= ST_SETTLE;
                     r_row        <= '0;
                     r_settle_cnt <= '0;
                     r_sample_cnt <= '0;
                     r_code_sh    <= '0;
                     r_unst_sh    <= '0;
                     r_busy       <= 1'b1;
                  end else begin
                     r_busy <= 1'b0;
                  end
               end

               ST_SETTLE: begin
                  if (r_settle_cnt == SETTLE_LAST) begin
                     r_state      <= ST_SAMPLE;
                     r_sample_cnt <= '0;
                  end else begin
                     r_settle_cnt <= r_settle_cnt + SETTLE_W'(1);
                  end
               end

               ST_SAMPLE: begin
                  // First sample defines the code bit; later ones only flag disagreement.
                  if (w_first_sample) begin
                     r_code_sh[w_bit_idx] <= i_dut_out;
                  end else if (i_dut_out != r_code_sh[w_bit_idx]) begin
                     r_unst_sh[w_bit_idx] <= 1'b1;
                  end

                  if (w_last_sample) begin
                     r_sample_cnt <= '0;
                     if (r_row == ROW_LAST) begin
                        r_state <= ST_DONE;
                        r_probe <= '0;
                     end else begin
                        r_state      <= ST_SETTLE;
                        r_row        <= w_row_next;
                        r_probe      <= w_row_next;
                        r_settle_cnt <= '0;
                     end
                  end else begin
                     r_sample_cnt <= r_sample_cnt + SAMPLE_W'(1);
                  end
               end

               ST_DONE: begin
                  // busy stays high here so it drops in the same edge as done.
                  r_code     <= r_code_sh;
                  r_unstable <= r_unst_sh;
                  r_done     <= 1'b1;
                  r_row      <= '0;
                  r_probe    <= '0;
                  r_state    <= ST_IDLE;
               end

               default: begin
                  r_state <= ST_IDLE;
                  r_probe <= '0;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_probe_in1 = r_probe[2];
   assign o_probe_in2 = r_probe[1];
   assign o_probe_in3 = r_probe[0];
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_code      = r_code;
   assign o_unstable  = r_unstable;

endmodule

// File: tb/tb_truth_table_prober.sv
// Bench for truth_table_prober: two instances (default timing and S=1/M=1),
// randomized gate behaviour checked against a time-indexed sample model.
module tb_truth_table_prober;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start_d, abort_d, dout_d;
   logic       p1_d, p2_d, p3_d, busy_d, done_d;
   logic [7:0] code_d, unst_d;
   logic       start_f, abort_f, dout_f;
   logic       p1_f, p2_f, p3_f, busy_f, done_f;
   logic [7:0] code_f, unst_f;

   truth_table_prober u_dut (
      .i_clk(clk), .i_rst(rst), .i_start(start_d), .i_abort(abort_d), .i_dut_out(dout_d),
      .o_probe_in1(p1_d), .o_probe_in2(p2_d), .o_probe_in3(p3_d),
      .o_busy(busy_d), .o_done(done_d), .o_code(code_d), .o_unstable(unst_d)
   );

   truth_table_prober #(.SETTLE_CYCLES(1), .SAMPLE_CYCLES(1)) u_dut_fast (
      .i_clk(clk), .i_rst(rst), .i_start(start_f), .i_abort(abort_f), .i_dut_out(dout_f),
      .o_probe_in1(p1_f), .o_probe_in2(p2_f), .o_probe_in3(p3_f),
      .o_busy(busy_f), .o_done(done_f), .o_code(code_f), .o_unstable(unst_f)
   );

   int errors = 0;
   int checks = 0;

   logic       sel;
   logic [2:0] cur_probes;
   logic       cur_busy, cur_done;
   logic [7:0] cur_code, cur_unst;
   logic [7:0] prev_code_d, prev_unst_d, prev_code_f, prev_unst_f;
   logic       log_v [0:255];

   always_comb begin
      if (sel) begin
         cur_probes = {p1_f, p2_f, p3_f};
         cur_busy   = busy_f;
         cur_done   = done_f;
         cur_code   = code_f;
         cur_unst   = unst_f;
      end else begin
         cur_probes = {p1_d, p2_d, p3_d};
         cur_busy   = busy_d;
         cur_done   = done_d;
         cur_code   = code_d;
         cur_unst   = unst_d;
      end
   end

   task automatic drive_start(input logic v);
      if (sel) start_f = v; else start_d = v;
   endtask

   task automatic drive_dout(input logic v);
      if (sel) dout_f = v; else dout_d = v;
   endtask

   // One full sweep. The gate is emulated from the probes; the expected code is
   // rebuilt from what was driven at each edge, using the documented sample times.
   task automatic run_sweep(input logic s, input logic [7:0] fn, input logic [7:0] rand_mask,
                            input logic [7:0] tog_mask, input bit chain_in, input bit chain_out,
                            input bit hold);
      int S, M, L, base;
      logic [7:0] exp_code, exp_unst, old_code, old_unst;
      logic tog, v, first, u;
      logic [2:0] row_now;
      sel = s;
      S = s ? 1 : 4;
      M = s ? 1 : 2;
      L = 8 * (S + M);
      old_code = s ? prev_code_f : prev_code_d;
      old_unst = s ? prev_unst_f : prev_unst_d;
      tog = 1'b0;
      if (!chain_in) begin
         drive_start(1'b1);
         @(posedge clk); #1;
         if (!hold) drive_start(1'b0);
      end
      for (int n = 0; n <= L + 2; n++) begin
         if (n < L) begin
            checks++;
            if (cur_probes !== 3'(n / (S + M))) begin
               errors++;
               $display("FAIL probes s=%0d n=%0d: got %0d expected %0d", s, n, cur_probes, n / (S + M));
            end
         end
         if (n == L + 2) begin
            checks++;
            if (cur_probes !== 3'd0) begin
               errors++;
               $display("FAIL probes_idle s=%0d: got %0d expected 0", s, cur_probes);
            end
         end
         checks++;
         if (cur_done !== (n == L + 1)) begin
            errors++;
            $display("FAIL done s=%0d n=%0d: got %0b expected %0b", s, n, cur_done, n == L + 1);
         end
         checks++;
         if (cur_busy !== ((n <= L + 1) || chain_out)) begin
            errors++;
            $display("FAIL busy s=%0d n=%0d: got %0b expected %0b", s, n, cur_busy,
                     (n <= L + 1) || chain_out);
         end
         if (n == L) begin
            checks++;
            if (cur_code !== old_code || cur_unst !== old_unst) begin
               errors++;
               $display("FAIL hold_code s=%0d: got %02h/%02h expected %02h/%02h", s,
                        cur_code, cur_unst, old_code, old_unst);
            end
         end
         if (n == L + 1) begin
            for (int r = 0; r < 8; r++) begin
               base  = r * (S + M) + S;
               first = log_v[base + 1];
               u     = 1'b0;
               for (int k = 2; k <= M; k++)
                  if (log_v[base + k] !== first) u = 1'b1;
               exp_code[7 - r] = first;
               exp_unst[7 - r] = u;
            end
            checks++;
            if (cur_code !== exp_code) begin
               errors++;
               $display("FAIL code s=%0d: got %02h expected %02h", s, cur_code, exp_code);
            end
            checks++;
            if (cur_unst !== exp_unst) begin
               errors++;
               $display("FAIL unstable s=%0d: got %02h expected %02h", s, cur_unst, exp_unst);
            end
            if (s) begin prev_code_f = exp_code; prev_unst_f = exp_unst; end
            else   begin prev_code_d = exp_code; prev_unst_d = exp_unst; end
         end
         if (n == L + 2) break;
         row_now = cur_probes;
         tog = ~tog;
         if (tog_mask[row_now])       v = tog;
         else if (rand_mask[row_now]) v = 1'($urandom_range(0, 1));
         else                         v = fn[3'(7 - row_now)];
         log_v[n + 1] = v;
         drive_dout(v);
         if (n == L + 1 && chain_out) drive_start(1'b1);
         @(posedge clk); #1;
      end
      if (chain_out && !hold) drive_start(1'b0);
   endtask

   task automatic test_reset;
      checks++;
      if ({p1_d, p2_d, p3_d, busy_d, done_d, code_d, unst_d} !== 21'd0) begin
         errors++;
         $display("FAIL reset_dflt: got %06h expected 000000", {p1_d, p2_d, p3_d, busy_d, done_d, code_d, unst_d});
      end
      checks++;
      if ({p1_f, p2_f, p3_f, busy_f, done_f, code_f, unst_f} !== 21'd0) begin
         errors++;
         $display("FAIL reset_fast: got %06h expected 000000", {p1_f, p2_f, p3_f, busy_f, done_f, code_f, unst_f});
      end
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy_d, done_d, code_d, unst_d} !== 18'd0) begin
         errors++;
         $display("FAIL post_reset_idle: got %05h expected 00000", {busy_d, done_d, code_d, unst_d});
      end
   endtask

   task automatic test_known_code;
      run_sweep(1'b0, 8'h29, 8'h00, 8'h00, 0, 0, 0);
      checks++;
      if (code_d !== 8'h29 || unst_d !== 8'h00) begin
         errors++;
         $display("FAIL code_0x29: got %02h/%02h expected 29/00", code_d, unst_d);
      end
   endtask

   task automatic test_back_to_back;
      run_sweep(1'b1, 8'hFF, 8'h00, 8'h00, 0, 1, 0);
      run_sweep(1'b1, 8'hFF, 8'h00, 8'h00, 1, 0, 0);
      checks++;
      if (code_f !== 8'hFF || unst_f !== 8'h00) begin
         errors++;
         $display("FAIL fast_const1: got %02h/%02h expected ff/00", code_f, unst_f);
      end
   endtask

   task automatic test_toggle;
      run_sweep(1'b0, 8'($urandom), 8'h00, 8'h20, 0, 0, 0);
      checks++;
      if (unst_d !== 8'h04) begin
         errors++;
         $display("FAIL toggle_row5: got %02h expected 04", unst_d);
      end
   endtask

   task automatic test_random_codes;
      for (int i = 0; i < 4; i++)
         run_sweep(1'b0, 8'($urandom), 8'($urandom & $urandom), 8'h00, 0, 0, 0);
      for (int i = 0; i < 2; i++)
         run_sweep(1'b1, 8'($urandom), 8'($urandom), 8'h00, 0, 0, 0);
   endtask

   task automatic test_abort;
      logic [7:0] fn;
      sel = 1'b0;
      fn  = 8'($urandom);
      start_d = 1'b1; @(posedge clk); #1; start_d = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         dout_d = fn[~cur_probes];
         @(posedge clk); #1;
      end
      checks++;
      if (cur_probes !== 3'd3) begin
         errors++;
         $display("FAIL abort_row3_reached: got %0d expected 3", cur_probes);
      end
      abort_d = 1'b1; @(posedge clk); #1; abort_d = 1'b0;
      checks++;
      if ({cur_probes, cur_busy, cur_done} !== 5'd0) begin
         errors++;
         $display("FAIL abort_idle: got %02h expected 00", {cur_probes, cur_busy, cur_done});
      end
      checks++;
      if (code_d !== prev_code_d || unst_d !== prev_unst_d) begin
         errors++;
         $display("FAIL abort_code_held: got %02h/%02h expected %02h/%02h", code_d, unst_d, prev_code_d, prev_unst_d);
      end
      for (int n = 0; n < 60; n++) begin
         @(posedge clk); #1;
         checks++;
         if (done_d !== 1'b0 || busy_d !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet n=%0d: got done=%0b busy=%0b expected 0/0", n, done_d, busy_d);
         end
      end
      // abort landing on the DONE cycle suppresses the pulse and the update
      start_d = 1'b1; @(posedge clk); #1; start_d = 1'b0;
      for (int n = 1; n <= 48; n++) begin
         dout_d = ~fn[~cur_probes];
         @(posedge clk); #1;
      end
      abort_d = 1'b1; @(posedge clk); #1; abort_d = 1'b0;
      checks++;
      if (done_d !== 1'b0 || busy_d !== 1'b0) begin
         errors++;
         $display("FAIL abort_in_done: got done=%0b busy=%0b expected 0/0", done_d, busy_d);
      end
      checks++;
      if (code_d !== prev_code_d || unst_d !== prev_unst_d) begin
         errors++;
         $display("FAIL abort_done_code: got %02h/%02h expected %02h/%02h", code_d, unst_d, prev_code_d, prev_unst_d);
      end
      // abort in IDLE is inert, so a simultaneous start is still accepted
      start_d = 1'b1; abort_d = 1'b1; @(posedge clk); #1; start_d = 1'b0; abort_d = 1'b0;
      checks++;
      if (busy_d !== 1'b1) begin
         errors++;
         $display("FAIL idle_abort_start: got busy=%0b expected 1", busy_d);
      end
      abort_d = 1'b1; @(posedge clk); #1; abort_d = 1'b0;
      checks++;
      if (busy_d !== 1'b0) begin
         errors++;
         $display("FAIL idle_abort_cancel: got busy=%0b expected 0", busy_d);
      end
   endtask

   task automatic test_start_held;
      sel = 1'b0;
      run_sweep(1'b0, 8'($urandom), 8'h00, 8'h00, 0, 1, 1);
      run_sweep(1'b0, 8'($urandom), 8'h00, 8'h00, 1, 1, 1);
      run_sweep(1'b0, 8'($urandom), 8'h00, 8'h00, 1, 1, 1);
      start_d = 1'b0;
      abort_d = 1'b1; @(posedge clk); #1; abort_d = 1'b0;
      checks++;
      if (busy_d !== 1'b0) begin
         errors++;
         $display("FAIL held_abort: got busy=%0b expected 0", busy_d);
      end
   endtask

   task automatic test_reset_mid;
      sel = 1'b0;
      start_d = 1'b1; @(posedge clk); #1; start_d = 1'b0;
      for (int n = 1; n <= 41; n++) begin
         dout_d = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      checks++;
      if (cur_probes !== 3'd6) begin
         errors++;
         $display("FAIL reset_mid_row6: got %0d expected 6", cur_probes);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({p1_d, p2_d, p3_d, busy_d, done_d, code_d, unst_d} !== 21'd0) begin
         errors++;
         $display("FAIL reset_mid_dflt: got %06h expected 000000", {p1_d, p2_d, p3_d, busy_d, done_d, code_d, unst_d});
      end
      checks++;
      if (code_f !== 8'h00 || unst_f !== 8'h00) begin
         errors++;
         $display("FAIL reset_mid_fast: got %02h/%02h expected 00/00", code_f, unst_f);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int n = 0; n < 60; n++) begin
         @(posedge clk); #1;
         checks++;
         if (done_d !== 1'b0 || busy_d !== 1'b0) begin
            errors++;
            $display("FAIL reset_quiet n=%0d: got done=%0b busy=%0b expected 0/0", n, done_d, busy_d);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      sel = 1'b0;
      start_d = 1'b0; abort_d = 1'b0; dout_d = 1'b0;
      start_f = 1'b0; abort_f = 1'b0; dout_f = 1'b0;
      prev_code_d = 8'h00; prev_unst_d = 8'h00;
      prev_code_f = 8'h00; prev_unst_f = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_known_code();
      test_back_to_back();
      test_toggle();
      test_random_codes();
      test_abort();
      test_start_held();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      if (errors == 0) $display("PASS");
      else             $display("FAIL");
      $finish;
   end

endmodule

// File: doc/truth_table_prober.md
# truth_table_prober

Sequential characterizer for 3-input single-output combinational gates: drives a device-under-test through all eight input rows, lets each row settle, samples the output, and assembles the 8-bit hex truth-table code by which our 3-input gates are named (e.g. 0x29). It closes the loop on the case-statement gate library: the library turns a code into logic, and this block turns logic back into a code. It sits in the gate-library self-check harness between a test controller and the DUT.

## Interface
- SETTLE_CYCLES, 4, cycles each row is held before sampling; legal range 1..255.
- SAMPLE_CYCLES, 2, consecutive samples taken per row; legal range 1..15.

- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a sweep; accepted only in IDLE.
- abort  input  1  cancel a sweep in progress.
- dut_out  input  1  DUT output under test.
- probe_in1  output  1  DUT input in1 (MSB of row index).
- probe_in2  output  1  DUT input in2.
- probe_in3  output  1  DUT input in3 (LSB of row index).
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when code/unstable are valid.
- code  output  8  truth-table code; code[7-r] = sampled output for row r = {in1,in2,in3}.
- unstable  output  8  unstable[7-r] set if samples for row r disagreed.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: probes = 000, busy = 0. On start=1: row ← 0, settle counter ← 0, clear the internal code/unstable shadow registers, go to SETTLE.
- SETTLE: probes = row. Counts SETTLE_CYCLES cycles, then goes to SAMPLE with sample counter ← 0.
- SAMPLE: probes = row. Each cycle registers dut_out. The first sample sets the shadow bit for row. Any later sample that differs from the first sets the row's unstable shadow bit. The code bit keeps the first sample. After SAMPLE_CYCLES samples: if row = 7, go to DONE; otherwise row ← row+1 and go to SETTLE.
- DONE: lasts one cycle. Copies the shadow registers to code/unstable, pulses done, returns to IDLE.
- code/unstable change only in DONE. They hold their value through IDLE, later sweeps and aborts until the next DONE.
- start while busy is ignored. start in the DONE cycle is ignored.
- abort (any non-IDLE state, including DONE): go to IDLE next cycle with probes 000 and no done pulse. code/unstable are unchanged. abort has priority over all other transitions. abort in IDLE has no effect, including when start is high in the same cycle.
- Row counter is 3 bits, strictly 0→7. There is no wrap within a sweep.
- Reset (any time, including mid-sweep): state IDLE, probes 000, busy 0, done 0, code 0x00, unstable 0x00, all counters 0.

## Timing
- start sampled at edge E0. Probes show row 0 and busy = 1 from E0.
- Row r is driven from edge E0 + r·(S+M) for S+M cycles, where S = SETTLE_CYCLES and M = SAMPLE_CYCLES.
- Samples for row r are taken at edges E0 + r·(S+M) + S + k, for k = 1..M.
- done = 1 for the single cycle starting at edge E0 + 8·(S+M) + 1. code/unstable are valid from that edge.
- busy falls together with done, at edge E0 + 8·(S+M) + 2.
- Back-to-back: the earliest next accepted start is sampled at edge E0 + 8·(S+M) + 2.
- Total sweep latency with defaults: 49 cycles from start to done.
- Outputs are registered. There is no combinational path from dut_out to any output.

## Test plan
- DUT = 0x29 function (rows 000..111 → 0,0,1,0,1,0,0,1), defaults -> done at start+49 cycles, code = 0x29, unstable = 0x00, probe sequence 0..7.
- DUT = constant 1, S=1, M=1 -> code = 0xFF, done at start+17, then start in the cycle after busy falls produces a second identical result.
- DUT toggles dut_out every cycle during row 5 only, M=2 -> unstable = 0x04, and code bit 2 equals the first sample.
- abort during row 3 -> IDLE next cycle, probes 000, no done, code keeps the prior sweep value (e.g. 0x29).
- rst asserted mid-SAMPLE of row 6 -> all outputs zero immediately (asynchronous), with no done pulse after release.
- start held high continuously, defaults -> sweeps every 50 cycles, one done pulse each, and start during busy has no effect on timing.
